fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Consumer for the read port of the 16-bit show-ahead FIFO (rdata valid while !empty; ren pops).
//  Drains words into a valid/ready stream framed into bursts of BURST_LEN beats, with out_last on the final beat.
//  Holds one word in a lookahead register so out_last is known when the beat is presented.
//  Sits between the FIFO and packet/DMA consumers.
// PARAMETERS
//  WIDTH      16   data word width; matches FIFO rdata
//  BURST_LEN  8    beats per full burst; legal range 2..256
//  TIMEOUT    32   idle cycles before a partial burst is closed; used only with FIFO_BURST_READER_TIMEOUT_EN
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  fifo_rdata  in   WIDTH  FIFO head word; valid while fifo_empty=0
//  fifo_empty  in   1      FIFO empty flag
//  fifo_ren    out  1      pop strobe; never asserted while fifo_empty=1
//  out_data    out  WIDTH  stream data (registered)
//  out_valid   out  1      stream valid (registered)
//  out_ready   in   1      downstream accept
//  out_last    out  1      final beat of the burst; qualified by out_valid
//  busy        out  1      hold_valid | out_valid
// BEHAVIOUR
//  Reset: all outputs 0; hold_valid=0, beat_cnt=0, timer=0. Async assert discards held and output words mid-burst.
//   The next burst starts at beat 0. FIFO pointers are not touched.
//  Stages: H (hold reg + hold_valid), O (out_data/out_valid/out_last). o_free = !out_valid | out_ready.
//  Release H->O when hold_valid & o_free & one of:
//   (a) beat_cnt==BURST_LEN-1 -> out_last=1, beat_cnt<=0
//   (b) !fifo_empty           -> out_last=0, beat_cnt++
//   (c) timeout fired          -> out_last=1, beat_cnt<=0
//  Pop rule: fifo_ren = !fifo_empty & (!hold_valid | release). A popped word loads H in the same edge.
//   Sustained throughput is 1 word/cycle.
//  Latency: FIFO non-empty -> word enters O after two edges at minimum (H, then O on the next word or on burst end).
//  O holds out_data/out_last stable while out_valid & !out_ready. out_valid drops only after accept with no release.
//  Simultaneous pop + release: H takes the new word, O takes the old one. No bubble, no loss.
//  A lone word (BURST_LEN>1) stays in H until the next word arrives or the timeout fires.
//  beat_cnt width is $clog2(BURST_LEN). It never exceeds BURST_LEN-1 and wraps to 0 only on a release with last=1.
//  out_ready low for N cycles: H fills, and fifo_ren stays 0 until O drains. The FIFO absorbs the backpressure.
// CONFIGURATION
//  `FIFO_BURST_READER_TIMEOUT_EN defined:
//   timer counts while hold_valid & fifo_empty & o_free.
//   timer clears on any pop or release.
//   At timer==TIMEOUT-1, release (c) fires.
//  Not defined: no timer, so partial bursts wait indefinitely for more data. TIMEOUT is ignored and no timer flops exist.
// STRUCTURE
//  fifo_pkg: WORD_W=16, typedef logic [WORD_W-1:0] word_t, and the beat-count helper function (clog2 width).
//  Shared with the FIFO and its writer.
//  Sub-module stream_out_reg: O stage (load, hold-under-backpressure, last flag). Also reusable by other stream sources.
//  The top level holds H, beat_cnt, the timer and the release/pop logic. There is no explicit FSM.
//  hold_valid and beat_cnt form the state.
// TESTING
//  1 Reset: rst_n=0 with the FIFO holding 3 words -> fifo_ren=0, out_valid=0, busy=0. The FIFO is not popped.
//  2 Full burst, BURST_LEN=8, out_ready=1: push 0x0000..0x0007 -> 8 beats in order, out_last only on 0x0007.
//    Then 16 words -> 2 bursts, 1 beat/cycle with no bubbles.
//  3 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data stable and no pops beyond H.
//    After release, all words arrive in order and none are duplicated.
//  4 Partial burst with TIMEOUT_EN and TIMEOUT=32: push 3 words (0xA1,0xA2,0xA3) then stop.
//    -> 0xA1, 0xA2 pass; 0xA3 emits out_last=1 exactly 32 cycles after the FIFO goes empty; beat_cnt returns to 0.
//  5 Same stimulus without the macro: 0xA3 is held indefinitely, with busy=1.
//    Pushing 5 more words completes the burst with out_last on the 8th.
//  6 Async reset mid-burst (beat 4, out_valid=1, out_ready=0) -> outputs clear immediately.
//    Post-reset words restart at beat 0, with out_last on the 8th beat.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 16-bit show-ahead FIFO, its writer and its burst reader.
// Provides the word type and a helper that sizes beat counters.
package fifo_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Counter width for a count running 0..n-1; never narrower than one bit.
    function automatic int beat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// stream_out_reg: registered output stage of a valid/ready stream.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// While valid is 1 and ready is 0, data and last are held unchanged.
// The source may load only when the stage is free (!valid | ready).
module stream_out_reg
    import fifo_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last
);

    // Take a new beat when loaded; otherwise drop valid once the held beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO into a valid/ready stream framed
// into bursts of BURST_LEN beats with out_last on the final beat.
// One word waits in a hold register so the last flag is known when the beat
// moves to the output stage.
// Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to close a partial
// burst after TIMEOUT idle cycles; without it partial bursts wait for data.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int            CW        = beat_w(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    // Reject parameter values outside the supported range at elaboration.
    if (BURST_LEN < 2 || BURST_LEN > 256 || TIMEOUT < 2) begin : g_bad_param
        $error("fifo_burst_reader: BURST_LEN must be 2..256 and TIMEOUT at least 2");
    end

    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic [CW-1:0]    beat_cnt;

    logic o_free;
    logic at_last;
    logic timeout_fire;
    logic release_beat;
    logic release_last;
    logic pop;

    assign o_free  = !out_valid | out_ready;
    assign at_last = (beat_cnt == LAST_BEAT);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int            TW        = beat_w(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;

    assign timeout_fire = hold_valid & fifo_empty & o_free & (timer == TIMER_MAX);

    // Idle timer: runs while a held word is starved of successors, restarts on any movement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (pop | release_beat) begin
            timer <= '0;
        end else if (hold_valid & fifo_empty & o_free) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // The held word moves on when the output stage is free and either the burst
    // ends on it, a successor word is available, or the idle timer expires.
    assign release_beat = hold_valid & o_free & (at_last | !fifo_empty | timeout_fire);

    // A release without a waiting successor can only be a timeout, which closes the burst.
    assign release_last = at_last | fifo_empty;

    // Pop whenever the hold register is empty or being vacated this cycle.
    // Gated by reset so a waiting FIFO is never drained while the block is held in reset.
    assign pop      = rst_n & !fifo_empty & (!hold_valid | release_beat);
    assign fifo_ren = pop;

    assign busy = hold_valid | out_valid;

    // Hold register: loads the popped word; empties when released with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (pop) begin
            hold_data  <= fifo_rdata;
            hold_valid <= 1'b1;
        end else if (release_beat) begin
            hold_valid <= 1'b0;
        end
    end

    // Beat position within the current burst; wraps only on a released last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (release_beat) begin
            beat_cnt <= release_last ? '0 : beat_cnt + 1'b1;
        end
    end

    stream_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (release_beat),
        .load_data(hold_data),
        .load_last(release_last),
        .ready    (out_ready),
        .data     (out_data),
        .valid    (out_valid),
        .last     (out_last)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (BURST_LEN=8, TIMEOUT=32).
// A show-ahead FIFO model feeds the DUT; accepted beats are collected and
// compared against hand-computed expected beats {last, data}.
module tb_fifo_burst_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    logic [15:0] mem [256];
    logic [7:0]  rd_ptr;
    logic [7:0]  wr_ptr;

    logic [16:0] exp_q [$];
    logic [16:0] got_q [$];

    int checks;
    int passes;
    int ren_err;

    fifo_burst_reader #(
        .WIDTH    (16),
        .BURST_LEN(8),
        .TIMEOUT  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .fifo_ren  (fifo_ren),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Clock / FIFO model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_rdata = mem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    // FIFO pops and stream acceptance both happen on the rising edge.
    always @(posedge clk) begin
        if (fifo_ren) begin
            if (fifo_empty) ren_err <= ren_err + 1;
            else            rd_ptr  <= rd_ptr + 8'd1;
        end
        if (rst_n && out_valid && out_ready) got_q.push_back({out_last, out_data});
    end

    // Driver tasks / scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_seq(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 16'(i);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    task automatic expect_seq(input logic [15:0] first, input int n, input logic last_at_end);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(last_at_end && i == n - 1), first + 16'(i)});
    endtask

    task automatic compare_beats(input string tag, input int budget);
        int waited;
        logic [16:0] e;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_beat_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) check({tag, "_beat"}, got_q.pop_front(), e);
            else                  check({tag, "_missing"}, 17'h1ffff, e);
        end
        got_q.delete();
    endtask

    // Directed sequence
    initial begin
        int cnt;
        logic found;
        checks    = 0;
        passes    = 0;
        ren_err   = 0;
        rd_ptr    = 8'd0;
        wr_ptr    = 8'd0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset with three words waiting in the FIFO.
        push_seq(16'h0000, 3);
        repeat (3) @(negedge clk);
        check("rst_ren",       fifo_ren,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_out_data",  out_data,  16'h0000);
        check("rst_busy",      busy,      1'b0);
        check("rst_not_popped", rd_ptr,   8'd0);

        // Full burst of 8 with out_last only on 0x0007.
        push_seq(16'h0003, 5);
        rst_n = 1'b1;
        expect_seq(16'h0000, 8, 1'b1);
        compare_beats("burst8", 40);

        // Sixteen words: two bursts, one beat per cycle without bubbles.
        @(negedge clk);
        push_seq(16'h0010, 16);
        expect_seq(16'h0010, 8, 1'b1);
        expect_seq(16'h0018, 8, 1'b1);
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (out_valid && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("burst16_contiguous", cnt, 16);
        compare_beats("burst16", 40);

        // Backpressure mid-burst.
        @(negedge clk);
        push_seq(16'h0030, 8);
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data_stable", out_data,  16'h0032);
            check("bp_valid",       out_valid, 1'b1);
            check("bp_no_pop",      fifo_ren,  1'b0);
        end
        check("bp_fifo_level", 8'(wr_ptr - rd_ptr), 8'd4);
        out_ready = 1'b1;
        expect_seq(16'h0030, 8, 1'b1);
        compare_beats("bp", 40);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // Partial burst closed by the idle timer.
        @(negedge clk);
        push_seq(16'h00A1, 3);
        cnt = 0;
        while (!fifo_empty && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (out_valid && out_last) found = 1'b1;
        end
        check("to_latency", cnt, 32);
        check("to_last_data", out_data, 16'h00A3);
        expect_seq(16'h00A1, 3, 1'b1);
        compare_beats("to_partial", 10);
        @(negedge clk);
        push_seq(16'h00B0, 8);
        expect_seq(16'h00B0, 8, 1'b1);
        compare_beats("to_restart", 40);
`else
        // Partial burst held until more data arrives.
        @(negedge clk);
        push_seq(16'h00A1, 3);
        repeat (50) @(negedge clk);
        check("hold_out_valid", out_valid, 1'b0);
        check("hold_busy",      busy,      1'b1);
        check("hold_ren",       fifo_ren,  1'b0);
        expect_seq(16'h00A1, 2, 1'b0);
        compare_beats("hold_partial", 5);
        push_seq(16'h00A4, 5);
        expect_seq(16'h00A3, 6, 1'b1);
        compare_beats("hold_complete", 40);
`endif

        // Asynchronous reset mid-burst while stalled on beat 4.
        @(negedge clk);
        push_seq(16'h0060, 8);
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (out_valid && out_data == 16'h0064) found = 1'b1;
        end
        out_ready = 1'b0;
        check("ar_reached_beat4", found, 1'b1);
        @(negedge clk);
        check("ar_stalled_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_out_last",  out_last,  1'b0);
        check("ar_out_data",  out_data,  16'h0000);
        check("ar_busy",      busy,      1'b0);
        check("ar_ren",       fifo_ren,  1'b0);
        expect_seq(16'h0060, 4, 1'b0);
        compare_beats("ar_before", 2);
        repeat (2) @(negedge clk);
        check("ar_fifo_level", 8'(wr_ptr - rd_ptr), 8'd2);
        push_seq(16'h0070, 6);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        expect_seq(16'h0066, 2, 1'b0);
        expect_seq(16'h0070, 6, 1'b1);
        compare_beats("ar_after", 40);

        check("ren_never_on_empty", ren_err, 0);

        // Final report
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
